num_node_fetcher: RTL and testbench

//  Downstream of the num_node BRAM writer. Streams the per-subgraph node count
//  out of the num_node BRAM (read port B) in subgraph order, addresses 0..NUM_SUBGRAPHS-1.

---
 rtl/num_node_fetcher.sv | 160 ++++++++++++++++
 tb/tb_num_node_fetcher.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/num_node_fetcher.sv
// num_node_fetcher: sweeps the num_node BRAM (port B) from address 0 to
// NUM_SUBGRAPHS-1 and hands each node count downstream over valid/ready.
// Reads are credit-limited against a small output FIFO, so a stalled consumer
// never causes a BRAM return to be dropped.
//
// Handshake: num_node_o/last_o are meaningful only while num_node_vld_o=1; a
// transfer happens on every cycle with num_node_vld_o & num_node_rdy_i; once
// valid is raised the head entry is held stable until it is transferred.
module num_node_fetcher #(
  parameter int NUM_SUBGRAPHS = 2708,
  parameter int MAX_NODES     = 168,
  parameter int READ_LATENCY  = 2,
  parameter int FIFO_DEPTH    = 4,
  localparam int NUM_NODE_WIDTH  = $clog2(MAX_NODES),
  localparam int NUM_NODE_ADDR_W = (NUM_SUBGRAPHS > 1) ? $clog2(NUM_SUBGRAPHS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [NUM_NODE_WIDTH-1:0]  num_node_bram_doutb,
  output logic                       num_node_bram_enb,
  output logic [NUM_NODE_ADDR_W-1:0] num_node_bram_addrb,
  output logic [NUM_NODE_WIDTH-1:0]  num_node_o,
  output logic                       num_node_vld_o,
  input  logic                       num_node_rdy_i,
  output logic                       last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  // Read address needs one extra code point so "all issued" (== NUM_SUBGRAPHS)
  // is representable without wrapping.
  localparam int RA_W  = $clog2(NUM_SUBGRAPHS + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [RA_W-1:0]           rd_addr_q;
  logic [READ_LATENCY-1:0]   vpipe_q;   // one bit per outstanding read, by age
  logic [READ_LATENCY-1:0]   lpipe_q;   // marks the read of the final address
  logic [NUM_NODE_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     fifo_last_q;
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          fifo_cnt_q;
  logic [CNT_W-1:0]          in_flight;
  logic                      credit_ok, issue, issue_last;
  logic                      push, pop, fifo_empty, fifo_full, head_last;

  // Count reads that are issued but whose data has not yet reached the FIFO.
  always_comb begin
    in_flight = '0;
    for (int k = 0; k < READ_LATENCY; k++) begin
      in_flight = in_flight + CNT_W'(vpipe_q[k]);
    end
  end

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign head_last  = fifo_last_q[rd_ptr_q];
  assign credit_ok  = (int'(fifo_cnt_q) + int'(in_flight)) < FIFO_DEPTH;
  assign issue      = (state_q == S_FETCH) && (rd_addr_q < RA_W'(NUM_SUBGRAPHS)) && credit_ok;
  assign issue_last = issue && (rd_addr_q == RA_W'(NUM_SUBGRAPHS - 1));
  assign push       = vpipe_q[READ_LATENCY-1];
  assign pop        = !fifo_empty && num_node_rdy_i;

  // Next-state logic for the sweep controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_FETCH;
      S_FETCH: if (issue_last) state_d = S_DRAIN;
      S_DRAIN: if (pop && head_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sweep controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Read address: cleared when a sweep is accepted, advanced on each issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      rd_addr_q <= '0;
    end else if (issue) begin
      rd_addr_q <= rd_addr_q + RA_W'(1);
    end
  end

  // Valid/last shift register tracking BRAM read latency; reset drops returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q <= '0;
      lpipe_q <= '0;
    end else begin
      vpipe_q[0] <= issue;
      lpipe_q[0] <= issue_last;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vpipe_q[k] <= vpipe_q[k-1];
        lpipe_q[k] <= lpipe_q[k-1];
      end
    end
  end

  // Output FIFO storage and pointers; the last tag travels with its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) fifo_data_q[k] <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= num_node_bram_doutb;
        fifo_last_q[wr_ptr_q] <= lpipe_q[READ_LATENCY-1];
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // FIFO occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // The read credit must make a push into a full FIFO impossible.
  no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

  assign num_node_bram_enb   = issue;
  assign num_node_bram_addrb = rd_addr_q[NUM_NODE_ADDR_W-1:0];
  assign num_node_vld_o      = !fifo_empty;
  assign num_node_o          = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
  assign last_o              = !fifo_empty && head_last;
  assign busy_o              = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done_o              = (state_q == S_DONE);

endmodule

// File: tb/tb_num_node_fetcher.sv
// Bench for num_node_fetcher: a default-sized instance driven through reset,
// full sweeps under several ready patterns, ignored starts and mid-sweep reset,
// plus two small instances (1 entry / latency 1, 5 entries / latency 4) swept
// under random ready.
module tb_num_node_fetcher;

  localparam int N     = 2708;
  localparam int RL    = 2;
  localparam int DEPTH = 4;
  localparam int W     = 8;
  localparam int AW    = 12;
  localparam logic [W-1:0] A_VAL = 8'd97;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main instance ----------------
  logic          start_i = 1'b0;
  logic          rdy = 1'b0;
  logic [W-1:0]  doutb, num_node;
  logic          enb, vld, last, busy, done;
  logic [AW-1:0] addrb;

  num_node_fetcher u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .num_node_bram_doutb(doutb), .num_node_bram_enb(enb), .num_node_bram_addrb(addrb),
    .num_node_o(num_node), .num_node_vld_o(vld), .num_node_rdy_i(rdy),
    .last_o(last), .busy_o(busy), .done_o(done)
  );

  logic [W-1:0] mem [1 << AW];
  logic [W-1:0] bram_p [RL];
  always @(posedge clk) begin
    bram_p[0] <= mem[addrb];
    for (int k = 1; k < RL; k++) bram_p[k] <= bram_p[k-1];
  end
  assign doutb = bram_p[RL-1];

  // ---------------- small instance a: 1 entry, latency 1 ----------------
  logic         a_rdy = 1'b0;
  logic [W-1:0] a_doutb, a_num;
  logic         a_enb, a_vld, a_last, a_busy, a_done;
  logic [0:0]   a_addrb;
  logic [W-1:0] a_p;

  num_node_fetcher #(.NUM_SUBGRAPHS(1), .READ_LATENCY(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .num_node_bram_doutb(a_doutb), .num_node_bram_enb(a_enb), .num_node_bram_addrb(a_addrb),
    .num_node_o(a_num), .num_node_vld_o(a_vld), .num_node_rdy_i(a_rdy),
    .last_o(a_last), .busy_o(a_busy), .done_o(a_done)
  );
  always @(posedge clk) a_p <= (a_addrb == 1'b0) ? A_VAL : 8'hEE;
  assign a_doutb = a_p;

  // ---------------- small instance b: 5 entries, latency 4 ----------------
  logic         b_rdy = 1'b0;
  logic [W-1:0] b_doutb, b_num;
  logic         b_enb, b_vld, b_last, b_busy, b_done;
  logic [2:0]   b_addrb;
  logic [W-1:0] b_p [4];

  function automatic logic [W-1:0] b_val(input int i);
    return W'((i * 53) % 168);
  endfunction

  num_node_fetcher #(.NUM_SUBGRAPHS(5), .READ_LATENCY(4), .FIFO_DEPTH(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .num_node_bram_doutb(b_doutb), .num_node_bram_enb(b_enb), .num_node_bram_addrb(b_addrb),
    .num_node_o(b_num), .num_node_vld_o(b_vld), .num_node_rdy_i(b_rdy),
    .last_o(b_last), .busy_o(b_busy), .done_o(b_done)
  );
  always @(posedge clk) begin
    b_p[0] <= b_val(int'(b_addrb));
    for (int k = 1; k < 4; k++) b_p[k] <= b_p[k-1];
  end
  assign b_doutb = b_p[3];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_enb"},   32'(enb),      0);
    check_eq({tag, "_addrb"}, 32'(addrb),    0);
    check_eq({tag, "_data"},  32'(num_node), 0);
    check_eq({tag, "_vld"},   32'(vld),      0);
    check_eq({tag, "_last"},  32'(last),     0);
    check_eq({tag, "_busy"},  32'(busy),     0);
    check_eq({tag, "_done"},  32'(done),     0);
  endtask

  // ---------------- ready drivers ----------------
  // rdy_mode: 0 always ready, 1 random 50%, 2 stall 20 cycles from 3rd output, 3 hands off
  int rdy_mode = 3;
  int stall_cnt = 0;
  int xfer_cnt = 0;

  always @(posedge clk) begin
    #1;
    a_rdy = 1'($urandom_range(0, 1));
    b_rdy = 1'($urandom_range(0, 1));
    case (rdy_mode)
      0: rdy = 1'b1;
      1: rdy = 1'($urandom_range(0, 1));
      2: begin
        if (xfer_cnt >= 2 && stall_cnt < 20) begin
          rdy = 1'b0;
          stall_cnt++;
        end else begin
          rdy = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard for main instance ----------------
  logic [W-1:0] exp_q [$];
  logic         mon_en = 1'b0;
  int           issued_cnt, done_cnt, first_vld_cyc, first_enb_cyc, last_xfer_cyc;
  logic [AW-1:0] first_enb_addr;
  logic         hold_prev, hold_last, last_pop_prev;
  logic [W-1:0] hold_data;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en && rst_n) begin
      if (enb) begin
        if (issued_cnt == 0) begin
          first_enb_cyc  = cyc;
          first_enb_addr = addrb;
        end
        issued_cnt++;
      end
      if (vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (hold_prev) begin
        check_eq("hold_vld",  32'(vld),      1);
        check_eq("hold_data", 32'(num_node), 32'(hold_data));
        check_eq("hold_last", 32'(last),     32'(hold_last));
      end
      hold_prev = vld && !rdy;
      hold_data = num_node;
      hold_last = last;
      if (rdy_mode == 2 && !rdy) begin
        check_eq("outstanding_le_depth", 32'((issued_cnt - xfer_cnt) <= DEPTH), 1);
        if (stall_cnt == 20) begin
          check_eq("stall_enb_stopped", 32'(enb), 0);
          check_eq("stall_vld_held",    32'(vld), 1);
        end
      end
      if (done) begin
        done_cnt++;
        check_eq("done_after_last_pop", 32'(last_pop_prev), 1);
      end
      last_pop_prev = 1'b0;
      if (vld && rdy) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_xfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("data", 32'(num_node), 32'(e));
          check_eq("last", 32'(last), 32'(exp_q.size() == 0));
          last_pop_prev = (exp_q.size() == 0);
        end
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
    end
  end

  // ---------------- small-instance monitors ----------------
  int a_idx = 0, a_done_cnt = 0, b_idx = 0, b_done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_idx = 0;
      b_idx = 0;
    end else begin
      if (a_vld && a_rdy) begin
        check_eq("a_data", 32'(a_num), 32'(A_VAL));
        check_eq("a_last", 32'(a_last), 32'(a_idx == 0));
        a_idx++;
      end
      if (a_done) begin
        check_eq("a_count", 32'(a_idx), 1);
        a_idx = 0;
        a_done_cnt++;
      end
      if (b_vld && b_rdy) begin
        check_eq("b_data", 32'(b_num), 32'(b_val(b_idx)));
        check_eq("b_last", 32'(b_last), 32'(b_idx == 4));
        b_idx++;
      end
      if (b_done) begin
        check_eq("b_count", 32'(b_idx), 5);
        b_idx = 0;
        b_done_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(output int t0);
    @(posedge clk);
    #1 start_i = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic prime_sweep(input int mode);
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
    xfer_cnt = 0; issued_cnt = 0; done_cnt = 0; stall_cnt = 0;
    first_vld_cyc = -1; first_enb_cyc = -1; last_xfer_cyc = -1;
    hold_prev = 1'b0; last_pop_prev = 1'b0;
    rdy_mode = mode;
    mon_en = 1'b1;
  endtask

  task automatic run_sweep(input int mode, input bit start_mid, input bit start_in_done);
    int t0;
    int guard;
    prime_sweep(mode);
    pulse_start(t0);
    if (start_mid) begin
      repeat (100) @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
    end
    guard = 0;
    while (done !== 1'b1 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("sweep_finished", 32'(guard < 20000), 1);
    if (start_in_done) begin
      start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check_eq("done_start_busy", 32'(busy), 0);
        check_eq("done_start_enb",  32'(enb),  0);
      end
    end else begin
      repeat (3) @(negedge clk);
    end
    check_eq("xfer_count",     32'(xfer_cnt),     N);
    check_eq("issue_count",    32'(issued_cnt),   N);
    check_eq("queue_drained",  32'(exp_q.size()), 0);
    check_eq("done_once",      32'(done_cnt),     1);
    check_eq("first_enb_lat",  32'(first_enb_cyc - t0), 1);
    check_eq("first_enb_addr", 32'(first_enb_addr), 0);
    check_eq("first_vld_lat",  32'(first_vld_cyc - t0), 2 + RL);
    if (mode == 0) check_eq("throughput", 32'(last_xfer_cyc - first_vld_cyc), N - 1);
    mon_en = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = W'(i % 168);

    // Reset held with random inputs: everything quiet.
    rst_n = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 start_i = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_all_zero("reset");
    end
    start_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check_eq("idle_enb", 32'(enb), 0);
      check_eq("idle_vld", 32'(vld), 0);
    end

    // Full sweep, always ready, mem[i] = i % 168.
    run_sweep(0, 1'b0, 1'b0);

    // Backpressure from the 3rd output.
    run_sweep(2, 1'b0, 1'b0);

    // Random contents (with some zero counts) under random ready.
    for (int i = 0; i < N; i++) mem[i] = W'($urandom_range(0, 167));
    for (int i = 0; i < 20; i++) mem[$urandom_range(0, N - 1)] = '0;
    run_sweep(1, 1'b0, 1'b0);

    // start_i mid-sweep and during DONE is ignored.
    run_sweep(0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a sweep.
    prime_sweep(1);
    begin
      int t0;
      pulse_start(t0);
    end
    repeat (300) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("post_reset_idle");

    // Clean sweep from address 0 after the reset.
    for (int i = 0; i < N; i++) mem[i] = W'((i * 7 + 3) % 168);
    run_sweep(0, 1'b0, 1'b0);

    repeat (20) @(negedge clk);
    check_eq("a_swept", 32'(a_done_cnt > 0), 1);
    check_eq("b_swept", 32'(b_done_cnt > 0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
